// File: rtl/mem_arbiter.sv
// Purpose : shares one single-port synchronous 64 KiB byte RAM between the CPU (port A)
//           and a loader/DMA requester (port B); A has priority, B is forced through after
//           STARVE_LIMIT consecutive lost contested cycles.
// Latency : grant is combinational (0 cycles); read data + RVALID one cycle after grant.
// Backpr. : an ungranted request is not queued; the requester holds REQ/ADDR/WE/WDATA
//           until it sees GNT in the same cycle.
// Ports   : CLK/RST (sync, active-high); A_*/B_* requester ports (REQ, WE, ADDR, WDATA in;
//           GNT, RVALID, RDATA out); MEM_WE/MEM_ADDR/MEM_DIN to the RAM, MEM_DOUT from it.
// Config  : define MEM_ARB_RR_EN for strict round-robin on contested cycles (no starve counter).
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        A_REQ,
  input  logic        A_WE,
  input  logic [15:0] A_ADDR,
  input  logic [7:0]  A_WDATA,
  output logic        A_GNT,
  output logic        A_RVALID,
  output logic [7:0]  A_RDATA,
  input  logic        B_REQ,
  input  logic        B_WE,
  input  logic [15:0] B_ADDR,
  input  logic [7:0]  B_WDATA,
  output logic        B_GNT,
  output logic        B_RVALID,
  output logic [7:0]  B_RDATA,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_DIN,
  input  logic [7:0]  MEM_DOUT
);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_A    = 2'd1,
    RD_B    = 2'd2
  } rd_port_e;

  rd_port_e rd_port_q, rd_port_d;
  logic     a_gnt, b_gnt, contested, b_wins;

`ifdef MEM_ARB_RR_EN
  // 1 when the most recent grant went to B; reset to 1 so A wins the first contest.
  logic last_b_q, last_b_d;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;
`endif

  // Arbitration: only contested cycles need a decision.
  always_comb begin
    contested = A_REQ & B_REQ;
`ifdef MEM_ARB_RR_EN
    b_wins = ~last_b_q;
`else
    b_wins = (starve_q == LIMIT);
`endif
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!RST) begin
      if (contested) begin
        a_gnt = ~b_wins;
        b_gnt = b_wins;
      end else begin
        a_gnt = A_REQ;
        b_gnt = B_REQ;
      end
    end
  end

  // RAM steering; idle bus is driven to zero so MEM_WE can never fire without a grant.
  always_comb begin
    MEM_WE   = 1'b0;
    MEM_ADDR = 16'h0000;
    MEM_DIN  = 8'h00;
    if (a_gnt) begin
      MEM_WE   = A_WE;
      MEM_ADDR = A_ADDR;
      MEM_DIN  = A_WDATA;
    end else if (b_gnt) begin
      MEM_WE   = B_WE;
      MEM_ADDR = B_ADDR;
      MEM_DIN  = B_WDATA;
    end
  end

  // Next-state: read owner tag, plus fairness state.
  always_comb begin
    rd_port_d = RD_NONE;
    if (a_gnt && !A_WE) begin
      rd_port_d = RD_A;
    end else if (b_gnt && !B_WE) begin
      rd_port_d = RD_B;
    end
`ifdef MEM_ARB_RR_EN
    last_b_d = last_b_q;
    if (b_gnt) begin
      last_b_d = 1'b1;
    end else if (a_gnt) begin
      last_b_d = 1'b0;
    end
`else
    // Counts only consecutive contested losses by B; saturates at the limit.
    starve_d = starve_q;
    if (b_gnt || !B_REQ) begin
      starve_d = 4'd0;
    end else if (contested && a_gnt && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_port_q <= RD_NONE;
`ifdef MEM_ARB_RR_EN
      last_b_q  <= 1'b1;
`else
      starve_q  <= 4'd0;
`endif
    end else begin
      rd_port_q <= rd_port_d;
`ifdef MEM_ARB_RR_EN
      last_b_q  <= last_b_d;
`else
      starve_q  <= starve_d;
`endif
    end
  end

  assign A_GNT    = a_gnt;
  assign B_GNT    = b_gnt;
  // A reset landing in the return cycle kills the pending read.
  assign A_RVALID = ~RST & (rd_port_q == RD_A);
  assign B_RVALID = ~RST & (rd_port_q == RD_B);
  assign A_RDATA  = MEM_DOUT;
  assign B_RDATA  = MEM_DOUT;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64 KiB synchronous RAM attached.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        A_REQ, A_WE, B_REQ, B_WE;
  logic [15:0] A_ADDR, B_ADDR;
  logic [7:0]  A_WDATA, B_WDATA;
  logic        A_GNT, A_RVALID, B_GNT, B_RVALID;
  logic [7:0]  A_RDATA, B_RDATA;
  logic        MEM_WE;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_DIN;
  logic [7:0]  MEM_DOUT;

  logic [7:0]  ram [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (MEM_WE) ram[MEM_ADDR] <= MEM_DIN;
    MEM_DOUT <= ram[MEM_ADDR];
  end

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [15:0] addr, input logic [7:0] wd);
    A_REQ = req; A_WE = we; A_ADDR = addr; A_WDATA = wd;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [15:0] addr, input logic [7:0] wd);
    B_REQ = req; B_WE = we; B_ADDR = addr; B_WDATA = wd;
  endtask

  // Bit i set = B expected to win contested cycle i.
`ifdef MEM_ARB_RR_EN
  logic [13:0] b_pat = 14'b10_1010_1010_1010;
`else
  logic [13:0] b_pat = 14'b00_0010_0001_0000;
`endif

  initial begin
    // Reset held with both ports requesting writes.
    RST = 1'b1;
    drive_a(1'b1, 1'b1, 16'h0108, 8'h11);
    drive_b(1'b1, 1'b1, 16'h0304, 8'h22);
    #1;
    chk("rst_a_gnt", A_GNT, 0);
    chk("rst_b_gnt", B_GNT, 0);
    chk("rst_mem_we", MEM_WE, 0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    drive_a(1'b0, 1'b0, 16'h0000, 8'h00);
    drive_b(1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    chk("post_rst_a_rvalid", A_RVALID, 0);
    chk("post_rst_b_rvalid", B_RVALID, 0);

    // Port A alone: write then back-to-back reads.
    next_cycle();
    drive_a(1'b1, 1'b1, 16'h0108, 8'h5A);
    #1;
    chk("a_wr_gnt", A_GNT, 1);
    chk("a_wr_b_gnt", B_GNT, 0);
    chk("a_wr_mem_we", MEM_WE, 1);
    chk("a_wr_mem_addr", MEM_ADDR, 16'h0108);
    chk("a_wr_mem_din", MEM_DIN, 8'h5A);
    next_cycle();
    drive_a(1'b1, 1'b0, 16'h0108, 8'h00);
    #1;
    chk("a_rd_gnt", A_GNT, 1);
    chk("a_rd_mem_we", MEM_WE, 0);
    chk("a_wr_no_rvalid", A_RVALID, 0);
    next_cycle();
    #1;
    chk("a_rd1_rvalid", A_RVALID, 1);
    chk("a_rd1_rdata", A_RDATA, 8'h5A);
    chk("a_rd1_b_rvalid", B_RVALID, 0);
    next_cycle();
    drive_a(1'b0, 1'b0, 16'h0108, 8'h33);
    #1;
    chk("a_rd2_rvalid", A_RVALID, 1);
    chk("a_rd2_rdata", A_RDATA, 8'h5A);
    next_cycle();
    #1;
    chk("idle_a_rvalid", A_RVALID, 0);
    chk("idle_mem_we", MEM_WE, 0);
    chk("idle_mem_addr", MEM_ADDR, 16'h0000);
    chk("idle_mem_din", MEM_DIN, 8'h00);

    // Cross-port coherence: B writes, A reads the same byte next cycle.
    next_cycle();
    drive_b(1'b1, 1'b1, 16'h0304, 8'hEE);
    #1;
    chk("b_wr_gnt", B_GNT, 1);
    chk("b_wr_a_gnt", A_GNT, 0);
    chk("b_wr_mem_we", MEM_WE, 1);
    chk("b_wr_mem_addr", MEM_ADDR, 16'h0304);
    chk("b_wr_mem_din", MEM_DIN, 8'hEE);
    next_cycle();
    drive_b(1'b0, 1'b0, 16'h0000, 8'h00);
    drive_a(1'b1, 1'b0, 16'h0304, 8'h00);
    #1;
    chk("x_rd_a_gnt", A_GNT, 1);
    next_cycle();
    drive_a(1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    chk("x_rd_a_rvalid", A_RVALID, 1);
    chk("x_rd_a_rdata", A_RDATA, 8'hEE);
    chk("x_rd_b_rvalid", B_RVALID, 0);

    // Reset with a write request pending: no grant, RAM untouched.
    next_cycle();
    RST = 1'b1;
    drive_a(1'b1, 1'b1, 16'h0108, 8'hFF);
    drive_b(1'b1, 1'b0, 16'h0304, 8'h00);
    #1;
    chk("rst_req_a_gnt", A_GNT, 0);
    chk("rst_req_b_gnt", B_GNT, 0);
    chk("rst_req_mem_we", MEM_WE, 0);

    // Contention: both ports read continuously.
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      RST = 1'b0;
      drive_a(1'b1, 1'b0, 16'h0108, 8'h00);
      drive_b(1'b1, 1'b0, 16'h0304, 8'h00);
      #1;
      chk($sformatf("cont_a_gnt_%0d", i), A_GNT, {31'd0, ~b_pat[i]});
      chk($sformatf("cont_b_gnt_%0d", i), B_GNT, {31'd0, b_pat[i]});
      if (i > 0) begin
        chk($sformatf("cont_a_rvalid_%0d", i), A_RVALID, {31'd0, ~b_pat[i-1]});
        chk($sformatf("cont_b_rvalid_%0d", i), B_RVALID, {31'd0, b_pat[i-1]});
      end
    end

    // Reset clears the starve counter: A wins the first contest afterwards.
    next_cycle();
    RST = 1'b1;
    #1;
    chk("rst2_a_gnt", A_GNT, 0);
    next_cycle();
    RST = 1'b0;
    #1;
    chk("after_rst_a_gnt", A_GNT, 1);
    chk("after_rst_b_gnt", B_GNT, 0);
    next_cycle();
    drive_a(1'b0, 1'b0, 16'h0000, 8'h00);
    drive_b(1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    chk("after_rst_a_rvalid", A_RVALID, 1);
    chk("no_write_in_rst", A_RDATA, 8'h5A);

    // Reset in the return cycle of a B read kills the strobe.
    next_cycle();
    drive_b(1'b1, 1'b0, 16'h0304, 8'h00);
    #1;
    chk("b_rd_gnt", B_GNT, 1);
    next_cycle();
    RST = 1'b1;
    drive_b(1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    chk("rst_mid_rd_b_rvalid", B_RVALID, 0);
    next_cycle();
    RST = 1'b0;
    #1;
    chk("post_mid_rd_b_rvalid", B_RVALID, 0);
    chk("post_mid_rd_a_rvalid", A_RVALID, 0);

    next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port synchronous 64 KiB byte RAM between the 6502 core (port A) and a loader/DMA requester (port B). Each cycle it grants at most one requester, steers that requester's address, write-enable and write data onto the RAM, and routes the RAM's registered read data back with a one-cycle-late valid strobe tagged to the owning port. Port A has priority; a starvation counter guarantees port B forward progress.

## Interface
- STARVE_LIMIT, 4: consecutive contested cycles port A may win before port B is forced through (1..15).
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- A_REQ  in  1  port A requests access this cycle.
- A_WE  in  1  port A write (1) / read (0).
- A_ADDR  in  16  port A byte address.
- A_WDATA  in  8  port A write data.
- A_GNT  out  1  port A owns the RAM this cycle (combinational).
- A_RVALID  out  1  A_RDATA holds data for port A's read granted last cycle.
- A_RDATA  out  8  read data to port A.
- B_REQ, B_WE, B_ADDR[15:0], B_WDATA[7:0], B_GNT, B_RVALID, B_RDATA[7:0]: identical meaning for port B.
- MEM_WE  out  1  RAM write enable.
- MEM_ADDR  out  16  RAM address.
- MEM_DIN  out  8  RAM write data.
- MEM_DOUT  in  8  RAM registered read data (valid one cycle after address presented).

## Operation
- Grant is combinational from REQ and registered arbiter state; forced 0 on both ports while RST=1.
- Only A_REQ: A granted. Only B_REQ: B granted. Neither: no grant, MEM_WE=0, MEM_ADDR=16'h0000, MEM_DIN=8'h00.
- Both requesting (contested): A granted unless starve counter == STARVE_LIMIT, then B granted.
- Starve counter (4 bits): +1 on each contested cycle won by A; cleared when B is granted or B_REQ=0; never exceeds STARVE_LIMIT.
- Muxing: MEM_WE/MEM_ADDR/MEM_DIN = granted port's WE/ADDR/WDATA; MEM_WE never 1 without a grant.
- Read return: register rd_port (A/B/none) each cycle = granted port if granted with WE=0, else none. Next cycle rd_port drives A_RVALID or B_RVALID high for exactly one cycle.
- A_RDATA and B_RDATA both pass MEM_DOUT directly; only the RVALID strobe distinguishes ownership.
- Writes produce no RVALID. Back-to-back reads from one port give RVALID on consecutive cycles.
- Requester holds REQ/ADDR/WE/WDATA until it sees GNT in the same cycle; an ungranted request is dropped silently from the arbiter's view and must be re-presented.

## Timing
- Reset values: A_RVALID=0, B_RVALID=0, rd_port=none, starve counter=0; A_GNT=B_GNT=0 and MEM_WE=0 while RST=1.
- Grant latency: 0 cycles (same cycle as REQ). Write commits at the rising edge ending the grant cycle.
- Read latency: RVALID and data one cycle after grant cycle.
- Same-address write by one port then read by the other next cycle returns the new data.
- RST asserted in the cycle after a granted read: RVALID suppressed (reads 0), read lost.
- RST asserted with REQ high: no grant, no write to RAM.
- Worst-case port B wait under continuous A_REQ: STARVE_LIMIT cycles, granted on cycle STARVE_LIMIT+1.

## Configuration
- MEM_ARB_RR_EN defined: fixed priority replaced by strict round-robin on contested cycles (grant goes to the port not granted in the most recent grant; after reset A wins first); starve counter and STARVE_LIMIT unused.
- MEM_ARB_RR_EN undefined: port A priority with starvation limit as above.

## Test plan
- Reset: hold RST=1 with A_REQ=B_REQ=1, A_WE=1 -> no GNT, MEM_WE=0; after release A_RVALID=B_RVALID=0.
- A alone: A writes 8'h5A to 16'h0108, next cycle A reads 16'h0108 -> A_RVALID=1 one cycle after read grant, A_RDATA=8'h5A, B_RVALID=0.
- Contention, STARVE_LIMIT=4: A_REQ and B_REQ held high 12 cycles -> grant pattern A,A,A,A,B,A,A,A,A,B,A,A.
- Cross-port coherence: B writes 8'hEE to 16'h0304, A reads 16'h0304 next cycle -> A_RDATA=8'hEE, A_RVALID only.
- Reset mid-read: B read granted, RST=1 next cycle -> B_RVALID=0, counter cleared, A wins first contested cycle after reset.
- MEM_ARB_RR_EN defined: both ports request continuously 6 cycles -> grants A,B,A,B,A,B.
